// File: rtl/mem_arbiter_if.sv
// Bundles both requester ports and the memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if;
    logic        p0_req;
    logic [31:0] p0_addr;
    logic        p0_rd_wr;
    logic [1:0]  p0_size;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_done;

    logic        p1_req;
    logic [31:0] p1_addr;
    logic        p1_rd_wr;
    logic [1:0]  p1_size;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_done;

    logic        mem_enable;
    logic        mem_rd_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out;
    logic        mem_busy;
    logic        err;

    modport slave (
        input  p0_req, p0_addr, p0_rd_wr, p0_size, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_done,
        input  p1_req, p1_addr, p1_rd_wr, p1_size, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_done,
        output mem_enable, mem_rd_wr, mem_addr, mem_data_in, mem_access_size,
        input  mem_data_out, mem_busy,
        output err
    );

    modport master (
        output p0_req, p0_addr, p0_rd_wr, p0_size, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_done,
        output p1_req, p1_addr, p1_rd_wr, p1_size, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_done,
        input  mem_enable, mem_rd_wr, mem_addr, mem_data_in, mem_access_size,
        output mem_data_out, mem_busy,
        input  err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between a fetch port (0) and a data port (1) sharing a 1 MB
// burst memory. Reads burst 1/4/8/16 words; writes are always a single word.
module mem_arbiter (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        last, owner, err_q, rd_wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q, done_q;
    logic        req0, req1, accept, winner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A port finishing this cycle is masked so the other port gets the next slot.
    always_comb begin
        state_next          = state;
        accept              = 1'b0;
        winner              = 1'b0;
        req0                = bus.p0_req && !done_q[0];
        req1                = bus.p1_req && !done_q[1];
        bus.mem_enable      = 1'b0;
        bus.mem_rd_wr       = 1'b0;
        bus.mem_access_size = 2'd0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    accept     = 1'b1;
                    winner     = (req0 && req1) ? ~last : req1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_enable      = 1'b1;
                bus.mem_rd_wr       = rd_wr_q;
                bus.mem_access_size = rd_wr_q ? size_q : 2'd0;
                state_next          = rd_wr_q ? BURST : IDLE;
            end
            BURST: begin
                bus.mem_enable      = (cnt != 4'd0);
                bus.mem_rd_wr       = 1'b1;
                bus.mem_access_size = size_q;
                if (cnt == 4'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.p0_rdata    = bus.mem_data_out;
    assign bus.p1_rdata    = bus.mem_data_out;
    assign bus.p0_gnt      = (state != IDLE) && !owner;
    assign bus.p1_gnt      = (state != IDLE) && owner;
    assign bus.p0_rvalid   = (state == BURST) && !owner;
    assign bus.p1_rvalid   = (state == BURST) && owner;
    assign bus.p0_done     = done_q[0];
    assign bus.p1_done     = done_q[1];
    assign bus.err         = err_q;

    // Dropping mem_enable on the last beat lets the memory clear its burst counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            last    <= 1'b1;
            owner   <= 1'b0;
            rd_wr_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            done_q <= 2'b00;
            if (accept) begin
                owner   <= winner;
                last    <= winner;
                addr_q  <= winner ? bus.p1_addr  : bus.p0_addr;
                rd_wr_q <= winner ? bus.p1_rd_wr : bus.p0_rd_wr;
                size_q  <= winner ? bus.p1_size  : bus.p0_size;
                wdata_q <= winner ? bus.p1_wdata : bus.p0_wdata;
            end
            if (state == ISSUE && rd_wr_q) begin
                case (size_q)
                    2'd0:    cnt <= 4'd0;
                    2'd1:    cnt <= 4'd3;
                    2'd2:    cnt <= 4'd7;
                    default: cnt <= 4'd15;
                endcase
            end else if (state == BURST && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if ((state == ISSUE && !rd_wr_q) || (state == BURST && cnt == 4'd0))
                done_q[owner] <= 1'b1;
            if (((state == IDLE || state == ISSUE) && bus.mem_busy) ||
                (state == BURST && cnt != 4'd0 && !bus.mem_busy))
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-port traffic, judged
// cycle by cycle against a transaction-level model and a shadow copy of memory.
module tb_mem_arbiter;
    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } txn_t;

    logic clk;
    logic reset;
    mem_arbiter_if bus();

    mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    logic [31:0] mem_words [0:262143];
    logic        mem_valid [0:262143];
    logic [31:0] ref_mem   [0:262143];
    logic        ref_valid [0:262143];
    logic        mem_active;
    logic [4:0]  mem_beat;
    logic [31:0] mem_out;
    logic        force_busy;

    txn_t        q0[$];
    txn_t        q1[$];
    txn_t        cur [2];
    logic [1:0]  cur_act, saw_done, prev_gnt;
    logic        inject_busy;
    int          grant_log[$];
    int          rv_count [2];
    int          done_cnt [2];
    logic [31:0] last_rdata [2];

    int          cyc, acc_cyc, t_n;
    logic        in_flight, t_own, t_rd, last_served, err_exp;
    logic [31:0] t_addr, t_wdata;
    logic [1:0]  t_size;

    assign bus.mem_data_out = mem_out;
    assign bus.mem_busy     = mem_active | force_busy;

    function automatic logic [31:0] wordInit(input logic [17:0] idx);
        return ({14'd0, idx} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] memRead(input logic [17:0] idx);
        return (mem_valid[idx] === 1'b1) ? mem_words[idx] : wordInit(idx);
    endfunction

    function automatic logic [31:0] refRead(input logic [17:0] idx);
        return (ref_valid[idx] === 1'b1) ? ref_mem[idx] : wordInit(idx);
    endfunction

    function automatic int burstWords(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (2 << size);
    endfunction

    // Memory: a read burst keeps streaming while enabled and forgets its position once enable drops.
    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_rd_wr) begin
            if (mem_active !== 1'b1) begin
                mem_out  <= memRead(bus.mem_addr[19:2]);
                mem_beat <= 5'd1;
            end else begin
                mem_out  <= memRead(bus.mem_addr[19:2] + 18'(mem_beat));
                mem_beat <= mem_beat + 5'd1;
            end
            mem_active <= 1'b1;
        end else begin
            if (bus.mem_enable) begin
                mem_words[bus.mem_addr[19:2]] <= bus.mem_data_in;
                mem_valid[bus.mem_addr[19:2]] <= 1'b1;
            end
            mem_active <= 1'b0;
            mem_beat   <= 5'd0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic pushTxn(input int port, input logic rd, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata);
        txn_t t;
        t.rd = rd; t.addr = addr; t.size = size; t.wdata = wdata;
        if (port == 0) q0.push_back(t);
        else           q1.push_back(t);
    endtask

    task automatic pushRandom(input int port);
        pushTxn(port, $urandom_range(0, 2) != 0, 32'($urandom_range(0, 32'h000F_FEFF)),
                2'($urandom_range(0, 3)), $urandom);
    endtask

    task automatic applyStimulus();
        for (int n = 0; n < 2; n++) begin
            if (cur_act[n] && saw_done[n]) cur_act[n] = 1'b0;
        end
        if (!cur_act[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); cur_act[0] = 1'b1; end
        if (!cur_act[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); cur_act[1] = 1'b1; end
        saw_done     = 2'b00;
        bus.p0_req   = cur_act[0];
        bus.p0_rd_wr = cur[0].rd;
        bus.p0_addr  = cur[0].addr;
        bus.p0_size  = cur[0].size;
        bus.p0_wdata = cur[0].wdata;
        bus.p1_req   = cur_act[1];
        bus.p1_rd_wr = cur[1].rd;
        bus.p1_addr  = cur[1].addr;
        bus.p1_size  = cur[1].size;
        bus.p1_wdata = cur[1].wdata;
        force_busy   = inject_busy;
    endtask

    // Model: a transaction accepted in cycle A owns the memory from A+1; reads give
    // rvalid on A+2..A+N+1 and done on A+N+2, writes give done on A+2.
    task automatic checkCycle();
        logic [1:0] exp_gnt, exp_rv, exp_done, obs_gnt, obs_rv, obs_done, masked;
        logic       exp_en, idle_now, burst_live, win;
        logic [31:0] rdata;
        int d, len;
        exp_gnt = 2'b00; exp_rv = 2'b00; exp_done = 2'b00; exp_en = 1'b0;
        d   = cyc - acc_cyc;
        len = t_rd ? t_n + 2 : 2;
        if (in_flight) begin
            if (d >= 1 && d <= len - 1)            exp_gnt[t_own]  = 1'b1;
            if (t_rd && d >= 2 && d <= t_n + 1)    exp_rv[t_own]   = 1'b1;
            if (d == len)                          exp_done[t_own] = 1'b1;
            exp_en = (d == 1) || (t_rd && d >= 2 && d <= t_n);
        end
        obs_gnt  = {bus.p1_gnt, bus.p0_gnt};
        obs_rv   = {bus.p1_rvalid, bus.p0_rvalid};
        obs_done = {bus.p1_done, bus.p0_done};
        checkOutput("gnt", 32'(obs_gnt), 32'(exp_gnt));
        checkOutput("rvalid", 32'(obs_rv), 32'(exp_rv));
        checkOutput("done", 32'(obs_done), 32'(exp_done));
        checkOutput("mem_enable", 32'(bus.mem_enable), 32'(exp_en));
        checkOutput("err", 32'(bus.err), 32'(err_exp));
        if (in_flight && d == 1) begin
            checkOutput("issue_addr", bus.mem_addr, t_addr);
            checkOutput("issue_rd_wr", 32'(bus.mem_rd_wr), 32'(t_rd));
            checkOutput("issue_size", 32'(bus.mem_access_size), t_rd ? 32'(t_size) : 32'd0);
            if (!t_rd) begin
                checkOutput("issue_wdata", bus.mem_data_in, t_wdata);
                ref_mem[t_addr[19:2]]   = t_wdata;
                ref_valid[t_addr[19:2]] = 1'b1;
            end
        end
        if (in_flight && t_rd && d >= 2 && d <= t_n + 1) begin
            checkOutput("rdata", t_own ? bus.p1_rdata : bus.p0_rdata,
                        refRead(t_addr[19:2] + 18'(d - 2)));
            checkOutput("burst_addr", bus.mem_addr, t_addr);
            checkOutput("burst_rd_wr", 32'(bus.mem_rd_wr), 32'd1);
        end
        for (int n = 0; n < 2; n++) begin
            rdata = (n == 1) ? bus.p1_rdata : bus.p0_rdata;
            if (obs_rv[n] === 1'b1) begin rv_count[n]++; last_rdata[n] = rdata; end
            if (obs_done[n] === 1'b1) begin done_cnt[n]++; saw_done[n] = 1'b1; end
            if (obs_gnt[n] === 1'b1 && prev_gnt[n] !== 1'b1) grant_log.push_back(n);
        end
        prev_gnt   = obs_gnt;
        idle_now   = !in_flight || d == len;
        burst_live = in_flight && t_rd && d >= 2 && d <= t_n;
        if (!reset && ((((idle_now || (in_flight && d == 1)) && bus.mem_busy === 1'b1)) ||
                       (burst_live && bus.mem_busy !== 1'b1)))
            err_exp = 1'b1;
        if (in_flight && d == len) in_flight = 1'b0;
        masked = {bus.p1_req && !exp_done[1], bus.p0_req && !exp_done[0]};
        if (!reset && !in_flight && masked != 2'b00) begin
            win         = (masked == 2'b11) ? ~last_served : masked[1];
            last_served = win;
            t_own       = win;
            in_flight   = 1'b1;
            acc_cyc     = cyc;
            t_rd        = win ? bus.p1_rd_wr : bus.p0_rd_wr;
            t_addr      = win ? bus.p1_addr  : bus.p0_addr;
            t_size      = win ? bus.p1_size  : bus.p0_size;
            t_wdata     = win ? bus.p1_wdata : bus.p0_wdata;
            t_n         = burstWords(t_size);
        end
    endtask

    task automatic runCycle();
        @(posedge clk);
        cyc++;
        #1;
        applyStimulus();
        @(negedge clk);
        checkCycle();
    endtask

    task automatic runUntilIdle(input int bound);
        int i;
        i = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cur_act != 2'b00 || in_flight) && i < bound) begin
            runCycle();
            i++;
        end
        if (i >= bound) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic modelReset();
        q0.delete();
        q1.delete();
        cur_act     = 2'b00;
        saw_done    = 2'b00;
        prev_gnt    = 2'b00;
        in_flight   = 1'b0;
        last_served = 1'b1;
        err_exp     = 1'b0;
        bus.p0_req  = 1'b0;
        bus.p1_req  = 1'b0;
    endtask

    task automatic clearCounters();
        grant_log.delete();
        for (int n = 0; n < 2; n++) begin
            rv_count[n] = 0; done_cnt[n] = 0; last_rdata[n] = 32'd0;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_gnt"}, 32'({bus.p1_gnt, bus.p0_gnt}), 32'd0);
        checkOutput({tag, "_rvalid"}, 32'({bus.p1_rvalid, bus.p0_rvalid}), 32'd0);
        checkOutput({tag, "_done"}, 32'({bus.p1_done, bus.p0_done}), 32'd0);
        checkOutput({tag, "_mem_ctl"}, 32'({bus.mem_enable, bus.mem_rd_wr, bus.mem_access_size}), 32'd0);
        checkOutput({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        checkOutput({tag, "_mem_data_in"}, bus.mem_data_in, 32'd0);
        checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int i;
        tests_run = 0; tests_failed = 0; cyc = 0; acc_cyc = 0; t_n = 1;
        t_own = 1'b0; t_rd = 1'b0; t_addr = 32'd0; t_wdata = 32'd0; t_size = 2'd0;
        inject_busy = 1'b0; force_busy = 1'b0;
        for (int n = 0; n < 2; n++) begin
            cur[n].rd = 1'b0; cur[n].addr = 32'd0; cur[n].size = 2'd0; cur[n].wdata = 32'd0;
        end
        modelReset();
        clearCounters();
        reset = 1'b1;
        repeat (3) runCycle();
        checkResetOutputs("reset");
        reset = 1'b0;

        // Simultaneous requests straight after reset, both held: port 0 first, then alternation.
        pushTxn(0, 1'b1, 32'h0000_0300, 2'd0, 32'd0);
        pushTxn(1, 1'b1, 32'h0000_0404, 2'd1, 32'd0);
        pushTxn(0, 1'b1, 32'h0000_0600, 2'd0, 32'd0);
        pushTxn(1, 1'b0, 32'h0000_0508, 2'd0, 32'h1111_2222);
        runUntilIdle(200);
        for (int k = 0; k < 4; k++)
            checkOutput("rr_order", (grant_log.size() > k) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(k % 2));

        clearCounters();
        pushTxn(0, 1'b1, 32'h0000_0100, 2'd1, 32'd0);
        runUntilIdle(100);
        checkOutput("p0_beats4", 32'(rv_count[0]), 32'd4);
        checkOutput("p0_last_beat", last_rdata[0], wordInit(18'h43));

        clearCounters();
        pushTxn(1, 1'b0, 32'h0000_0020, 2'd2, 32'hDEAD_BEEF);
        pushTxn(1, 1'b1, 32'h0000_0020, 2'd0, 32'd0);
        runUntilIdle(100);
        checkOutput("wb_readback", last_rdata[1], 32'hDEAD_BEEF);
        checkOutput("p1_done_count", 32'(done_cnt[1]), 32'd2);

        clearCounters();
        pushTxn(1, 1'b1, 32'h0000_4000, 2'd3, 32'd0);
        runCycle();
        pushTxn(0, 1'b1, 32'h0000_6000, 2'd0, 32'd0);
        runUntilIdle(100);
        checkOutput("p1_beats16", 32'(rv_count[1]), 32'd16);

        // Reset lands on the third beat of an 8-word read.
        clearCounters();
        pushTxn(0, 1'b1, 32'h0000_0800, 2'd2, 32'd0);
        i = 0;
        while (!(in_flight && cyc - acc_cyc == 4) && i < 20) begin
            runCycle();
            i++;
        end
        checkOutput("reach_beat3", 32'(rv_count[0]), 32'd3);
        reset = 1'b1;
        #1;
        checkResetOutputs("midburst");
        modelReset();
        repeat (2) runCycle();
        reset = 1'b0;
        repeat (2) runCycle();
        checkOutput("abandon_no_done", 32'(done_cnt[0]), 32'd0);
        pushTxn(0, 1'b1, 32'h0000_0800, 2'd0, 32'd0);
        runUntilIdle(50);
        checkOutput("post_reset_data", last_rdata[0], wordInit(18'h200));
        checkOutput("post_reset_err", 32'(bus.err), 32'd0);

        for (int c = 0; c < 400; c++) begin
            if (q0.size() < 2 && $urandom_range(0, 5) == 0) pushRandom(0);
            if (q1.size() < 2 && $urandom_range(0, 5) == 0) pushRandom(1);
            runCycle();
        end
        runUntilIdle(300);
        checkOutput("random_err", 32'(bus.err), 32'd0);

        inject_busy = 1'b1;
        runCycle();
        inject_busy = 1'b0;
        repeat (4) runCycle();
        checkOutput("err_sticky", 32'(bus.err), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("err_reset", 32'(bus.err), 32'd0);
        modelReset();
        repeat (2) runCycle();
        reset = 1'b0;
        repeat (2) runCycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters: none; the memory is fixed at 1 MB with word-addressed bursts of 1/4/8/16 words.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 pN_req  in  1  request from port N (N=0 fetch, N=1 data); held until pN_done.
REQ-005 pN_addr  in  32  byte address of first word.
REQ-006 pN_rd_wr  in  1  1=read, 0=write.
REQ-007 pN_size  in  2  burst code: 0=1, 1=4, 2=8, 3=16 words.
REQ-008 pN_wdata  in  32  write word.
REQ-009 pN_gnt  out  1  port N owns the memory, from ISSUE through the last beat.
REQ-010 pN_rvalid  out  1  pN_rdata holds a valid read beat this cycle.
REQ-011 pN_rdata  out  32  mem_data_out, passed through to both ports.
REQ-012 pN_done  out  1  one-cycle registered pulse: transaction complete.
REQ-013 mem_enable, mem_rd_wr  out  1 each; mem_addr, mem_data_in  out  32 each; mem_access_size  out  2; these drive the memory.
REQ-014 mem_data_out  in  32; mem_busy  in  1; both come from the memory.
REQ-015 err  out  1  sticky protocol error flag.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and BURST, and SHALL be Moore-style for all mem_* outputs.
REQ-017 IDLE: mem_enable=0. If any unmasked req is present, the arbiter SHALL latch the winner's addr/rd_wr/size/wdata and go to ISSUE.
REQ-018 Arbitration SHALL be round-robin with a 1-bit last-served pointer: a sole requester wins; on a tie, the port != last wins. The pointer SHALL update at acceptance.
REQ-019 A port whose pN_done is high in the current cycle SHALL be masked from arbitration in that cycle.
REQ-020 ISSUE lasts exactly 1 cycle:
- mem_enable=1; mem_addr, mem_rd_wr and mem_data_in come from the latched values.
- mem_access_size = latched size for reads, 0 for writes (writes are always single-word).
REQ-021 ISSUE, write: the write SHALL occur at the ISSUE edge; the FSM goes to IDLE and pN_done=1 in the following cycle.
REQ-022 ISSUE, read: beat counter cnt SHALL load N-1 (0/3/7/15); the FSM goes to BURST.
REQ-023 BURST, each cycle: pN_rvalid=1 for the owner; mem_enable=(cnt!=0); mem_rd_wr=1; address held.
- At the edge: if cnt!=0, cnt decrements and the FSM stays in BURST.
- If cnt==0, the FSM goes to IDLE and pN_done=1 in the next cycle.
REQ-024 A read of N words SHALL produce exactly N consecutive rvalid cycles, starting the cycle after ISSUE. Total latency from acceptance to done SHALL be N+2 cycles for reads and 2 cycles for writes.
REQ-025 mem_enable SHALL be 0 in the cycle after the last beat, so the memory neither restarts a read nor misses its burst-counter clear.
REQ-026 The next transaction's ISSUE SHALL be no earlier than 1 cycle after done (back-to-back: done and acceptance share the same IDLE cycle).
REQ-027 err SHALL be set if mem_busy=1 while in IDLE or ISSUE, or if mem_busy=0 in BURST with cnt!=0. err SHALL clear only on reset.
REQ-028 Byte address bits [1:0] SHALL be passed through unmodified; bursts crossing the top of memory are undefined and not checked.

Reset
REQ-029 While reset=1, and asynchronously on assertion, the block SHALL force:
- state=IDLE, cnt=0, last=1 (port 0 wins the first tie), err=0;
- all pN_gnt/pN_rvalid/pN_done=0;
- mem_enable=0, mem_rd_wr=0, mem_access_size=0, mem_addr=0, mem_data_in=0.
REQ-030 Reset mid-burst SHALL abandon the transaction with no done. The memory's burst counter then clears on the next edge because mem_enable=0.

Verification
REQ-031 p0 read, addr 0x100, size 1 -> ISSUE next cycle; 4 rvalid beats = mem words 0x40..0x43; p0_done on cycle 6 after acceptance.
REQ-032 p1 write, addr 0x20, wdata 0xDEADBEEF, size 2 -> mem_access_size=0, a single write, p1_done 2 cycles after acceptance; a following 1-word read of 0x20 returns 0xDEADBEEF.
REQ-033 p0 and p1 request together after reset -> p0 served first, then p1; with both held continuously, grants alternate 0,1,0,1.
REQ-034 p1 read of 16 words with p0 requesting throughout -> 16 contiguous p1_rvalid beats, no p0_gnt until after p1_done, mem_enable=0 in the cycle after beat 16.
REQ-035 Reset asserted on the 3rd beat of an 8-word read -> all outputs 0 immediately, no done; the next 1-word read returns the correct data with err=0.
REQ-036 mem_busy forced to 1 in IDLE -> err=1 next cycle and stays 1 until reset.
